// File: rtl/reg_dump_pkg.sv
// Shared types for the register-file dumper.
// State encoding and index-width helper.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        EMIT0,
        EMIT1,
        DONE
    } state_t;

    localparam int NREGS_DEF = 32;

    function automatic int addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/reg_file_dumper_if.sv
// Valid/ready word stream carrying one register per beat.
// master drives data, slave drives ready.
interface reg_file_dumper_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_idx;
    logic              out_last;

    modport master (
        output out_valid, out_data, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_file_dumper.sv
// Dumps a register file as a stream, optionally zero-filling it first.
// Zero-fill pass is built only when REG_DUMP_CLEAR_EN is defined.
module reg_file_dumper
    import reg_dump_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int DATA_W = 32,
    parameter int ADDR_W = addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    output logic              busy,
    output logic              done,
    output logic              wren,
    output logic [ADDR_W-1:0] wr,
    output logic [DATA_W-1:0] wd,
    output logic [ADDR_W-1:0] rr1,
    output logic [ADDR_W-1:0] rr2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    reg_file_dumper_if.master out
);

    localparam logic [ADDR_W-2:0] K_LAST = (ADDR_W-1)'(NREGS/2-1);

    state_t            state, nxt;
    logic [ADDR_W-2:0] k, k_nxt;
    logic [DATA_W-1:0] buf0, buf1;
    logic              hs, last;

    assign hs   = out.out_valid & out.out_ready;
    assign last = (k == K_LAST);

`ifdef REG_DUMP_CLEAR_EN
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(NREGS-1);
    logic [ADDR_W-1:0] c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c <= '0;
        end else if (state == IDLE && start) begin
            c <= '0;
        end else if (state == CLEAR && c != C_LAST) begin
            c <= c + 1'b1;
        end
    end

    // Gated by rst_n so the write at the reset edge is suppressed.
    assign wren = (state == CLEAR) & rst_n;
    assign wr   = c;
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign wren = 1'b0;
    assign wr   = '0;
`endif
    assign wd = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            buf0  <= '0;
            buf1  <= '0;
            rr1   <= '0;
            rr2   <= '0;
        end else begin
            state <= nxt;
            k     <= k_nxt;
            if (state == READ) begin
                buf0 <= rd1;
                buf1 <= rd2;
            end
            if (nxt == READ) begin
                rr1 <= {k_nxt, 1'b0};
                rr2 <= {k_nxt, 1'b1};
            end
        end
    end

    always_comb begin
        nxt   = state;
        k_nxt = k;
        unique case (state)
            IDLE: if (start) begin
                k_nxt = '0;
`ifdef REG_DUMP_CLEAR_EN
                nxt = clear ? CLEAR : READ;
`else
                nxt = READ;
`endif
            end
`ifdef REG_DUMP_CLEAR_EN
            CLEAR: if (c == C_LAST) nxt = READ;
`endif
            READ:  nxt = EMIT0;
            EMIT0: if (hs) nxt = EMIT1;
            EMIT1: if (hs) begin
                if (last) begin
                    nxt = DONE;
                end else begin
                    k_nxt = k + 1'b1;
                    nxt   = READ;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        out.out_valid = (state == EMIT0) || (state == EMIT1);
        out.out_data  = (state == EMIT1) ? buf1 : buf0;
        out.out_idx   = {k, state == EMIT1};
        out.out_last  = (state == EMIT1) && last;
    end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Randomized bench: dumper paired with a behavioural register file.
// Expected stream comes from a snapshot of the reference register array.
module tb_reg_file_dumper;

    localparam int N  = 32;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n, start, clear;
    logic          busy, done, wren;
    logic [AW-1:0] wr, rr1, rr2;
    logic [DW-1:0] wd, rd1, rd2;
    logic [DW-1:0] rf  [N];
    logic [DW-1:0] mdl [N];
    int            checks = 0;
    int            errors = 0;

`ifdef REG_DUMP_CLEAR_EN
    localparam bit CLR_BUILT = 1'b1;
`else
    localparam bit CLR_BUILT = 1'b0;
`endif

    reg_file_dumper_if #(.DATA_W(DW), .ADDR_W(AW)) sif ();

    reg_file_dumper #(.NREGS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .busy(busy), .done(done), .wren(wren), .wr(wr), .wd(wd),
        .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2), .out(sif)
    );

    always #5 clk = ~clk;

    assign rd1 = rf[rr1];
    assign rd2 = rf[rr2];
    always @(posedge clk) if (wren) rf[wr] <= wd;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int mode);
        for (int i = 0; i < N; i++) begin
            rf[i]  = (mode == 1) ? DW'(i * 3) : $urandom;
            mdl[i] = rf[i];
        end
    endtask

    task automatic check_rf(input string tag);
        int bad = 0;
        for (int i = 0; i < N; i++) if (rf[i] !== mdl[i]) bad++;
        chk(tag, bad, 0);
    endtask

    // ready mode: 0 = tied 1, 1 = toggle, 2 = random
    task automatic run_dump(input bit clr, input int rmode,
                            input bit restart, input int exp_done_t);
        logic [DW-1:0] exp_w [N];
        logic [DW-1:0] p_data;
        logic [AW-1:0] p_idx;
        logic          p_last, stall, r, fin;
        bit            eff;
        int            nw, nwr, nd, done_t;
        eff = clr && CLR_BUILT;
        for (int i = 0; i < N; i++) exp_w[i] = eff ? '0 : mdl[i];
        nw = 0; nwr = 0; nd = 0; done_t = -1;
        stall = 0; fin = 0; p_data = '0; p_idx = '0; p_last = 0;
        @(negedge clk);
        start = 1'b1; clear = clr; sif.out_ready = 1'b1;
        for (int t = 1; t < 600; t++) begin
            @(negedge clk);
            start = restart && (t == 20);
            clear = restart && (t == 20);
            if (nd > 0 && t == done_t + 1) begin
                chk("busy_after_done", busy, 0);
                chk("done_one_cycle", done, 0);
                fin = 1;
                break;
            end
            if (wren) begin
                chk("wr_seq", wr, nwr);
                chk("wd_zero", wd, 0);
                nwr++;
            end
            if (done) begin
                nd++;
                done_t = t;
            end
            if (stall) begin
                chk("stall_valid", sif.out_valid, 1);
                chk("stall_data", sif.out_data, p_data);
                chk("stall_idx", sif.out_idx, p_idx);
                chk("stall_last", sif.out_last, p_last);
            end
            case (rmode)
                1:       r = t[0];
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            sif.out_ready = r;
            if (sif.out_valid && r) begin
                if (nw < N) begin
                    chk("idx", sif.out_idx, nw);
                    chk("data", sif.out_data, exp_w[nw]);
                    chk("last", sif.out_last, nw == N - 1);
                end else begin
                    chk("extra_word", nw, N - 1);
                end
                nw++;
            end
            stall  = sif.out_valid && !r;
            p_data = sif.out_data;
            p_idx  = sif.out_idx;
            p_last = sif.out_last;
        end
        chk("timeout", fin, 1);
        chk("words", nw, N);
        chk("wren_count", nwr, eff ? N : 0);
        chk("done_count", nd, 1);
        if (exp_done_t >= 0) chk("done_time", done_t, exp_done_t);
        if (eff) for (int i = 0; i < N; i++) mdl[i] = '0;
        check_rf("rf_after_dump");
        sif.out_ready = 1'b1;
    endtask

    initial begin
        logic hit;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; sif.out_ready = 1'b0;
        preload(0);
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wren", wren, 0);
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_last", sif.out_last, 0);
        chk("rst_addr", {wr, rr1, rr2, sif.out_idx}, 0);
        chk("rst_data", {wd, sif.out_data}, 0);
        rst_n = 1'b1;

        preload(0);
        rf[1] = 32'hffaa7788; mdl[1] = rf[1];
        rf[2] = 32'h10;       mdl[2] = rf[2];
        run_dump(1'b0, 0, 1'b0, 49);

        preload(1);
        run_dump(1'b1, 0, 1'b0, CLR_BUILT ? 81 : 49);

        preload(0);
        run_dump(1'b0, 1, 1'b0, -1);

        preload(0);
        run_dump(1'b0, 0, 1'b1, 49);

        preload(0);
        run_dump(1'b0, 2, 1'b0, -1);

        preload(1);
        run_dump(1'b1, 2, 1'b0, -1);

        preload(0);
        @(negedge clk);
        start = 1'b1; clear = 1'b1; sif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        hit = 0;
        for (int t = 0; t < 100; t++) begin
            if (CLR_BUILT ? (wren && wr == 5)
                          : (sif.out_valid && sif.out_idx == 5)) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reset_point_found", hit, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_wren", wren, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", sif.out_valid, 0);
        rst_n = 1'b1;
        if (CLR_BUILT) for (int i = 0; i < 5; i++) mdl[i] = '0;
        check_rf("rf_after_midrst");
        repeat (3) @(negedge clk);
        chk("idle_after_rst", {busy, wren, sif.out_valid}, 0);

        preload(0);
        run_dump(1'b0, 0, 1'b0, 49);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
